// File: rtl/pkt_rx_pkg.sv
// Shared types and constants for the packet receive framer.
package pkt_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PID,
        DATA,
        DONE,
        ERR
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'h80;
    localparam int         MAX_PAYLOAD_DEF = 64;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;

    // A PID byte carries its nibble in [3:0] and the complement in [7:4].
    function automatic logic pid_ok(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up counter with clear, enable and a programmable rollover value.
// rollover_flag is high while count_out equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] next_count;

    // Next count: clear wins, otherwise step and wrap to 1 after rollover_val.
    always_comb begin
        next_count = count_out;
        if (clear) begin
            next_count = '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                next_count = NUM_CNT_BITS'(1);
            end else begin
                next_count = count_out + NUM_CNT_BITS'(1);
            end
        end
    end

    // Count register with the flag registered from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= (next_count == rollover_val);
        end
    end

endmodule

// File: rtl/pkt_rx_framer.sv
// Receive-path framer: finds SYNC, validates the PID, forwards payload bytes
// and reports length or error. Payload is counted by an external flex_counter.
module pkt_rx_framer
    import pkt_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         MAX_PAYLOAD = MAX_PAYLOAD_DEF,
    parameter int         CNT_BITS    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                eop,
    output logic                cnt_clear,
    output logic                cnt_enable,
    output logic [CNT_BITS-1:0] cnt_rollover_val,
    input  logic [CNT_BITS-1:0] cnt_count,
    input  logic                cnt_rollover,
    output logic                out_valid,
    output logic [7:0]          out_data,
    output logic [3:0]          pid_out,
    output logic                pkt_start,
    output logic                pkt_done,
    output logic [CNT_BITS-1:0] pkt_len,
    output logic                pkt_err
);

    rx_state_t state;
    // Set when the eop that ends the packet was already seen on entry to ERR.
    logic      err_exit;

    logic sync_hit;
    logic accept;
    logic overflow;

    assign sync_hit = (state == IDLE) && byte_valid && (byte_data == SYNC_BYTE);
    // A full counter (rollover flag up) means this byte would exceed the limit.
    assign accept   = (state == DATA) && byte_valid && !cnt_rollover;
    assign overflow = (state == DATA) && byte_valid && cnt_rollover;

    assign cnt_clear        = rst || sync_hit;
    assign cnt_enable       = accept && !rst;
    assign cnt_rollover_val = CNT_BITS'(MAX_PAYLOAD);

    // Framing FSM with registered pulse and data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            err_exit  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            pid_out   <= '0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_len   <= '0;
            pkt_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_hit) begin
                        state <= PID;
                    end
                end
                PID: begin
                    if (eop) begin
                        state    <= ERR;
                        pkt_err  <= 1'b1;
                        err_exit <= 1'b1;
                    end else if (byte_valid) begin
                        if (pid_ok(byte_data)) begin
                            pid_out   <= byte_data[3:0];
                            pkt_start <= 1'b1;
                            state     <= DATA;
                        end else begin
                            state    <= ERR;
                            pkt_err  <= 1'b1;
                            err_exit <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_data  <= byte_data;
                    end
                    if (overflow) begin
                        state    <= ERR;
                        pkt_err  <= 1'b1;
                        err_exit <= eop;
                    end else if (eop) begin
                        // Length includes a byte accepted in this same cycle.
                        state    <= DONE;
                        pkt_done <= 1'b1;
                        pkt_len  <= cnt_count + CNT_BITS'(accept);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    if (eop || err_exit) begin
                        state    <= IDLE;
                        err_exit <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_rx_framer.sv
// Self-checking bench for pkt_rx_framer wired to a flex_counter.
module tb_pkt_rx_framer;

    localparam int CNT_BITS = 7;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                byte_valid = 1'b0;
    logic [7:0]          byte_data = 8'h00;
    logic                eop = 1'b0;
    logic                cnt_clear;
    logic                cnt_enable;
    logic [CNT_BITS-1:0] cnt_rollover_val;
    logic [CNT_BITS-1:0] cnt_count;
    logic                cnt_rollover;
    logic                out_valid;
    logic [7:0]          out_data;
    logic [3:0]          pid_out;
    logic                pkt_start;
    logic                pkt_done;
    logic [CNT_BITS-1:0] pkt_len;
    logic                pkt_err;

    pkt_rx_framer #(.SYNC_BYTE(8'h80), .MAX_PAYLOAD(64), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .eop(eop),
        .cnt_clear(cnt_clear), .cnt_enable(cnt_enable), .cnt_rollover_val(cnt_rollover_val),
        .cnt_count(cnt_count), .cnt_rollover(cnt_rollover),
        .out_valid(out_valid), .out_data(out_data), .pid_out(pid_out),
        .pkt_start(pkt_start), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_err(pkt_err)
    );

    flex_counter #(.NUM_CNT_BITS(CNT_BITS)) u_cnt (
        .clk(clk), .rst(rst), .clear(cnt_clear), .count_enable(cnt_enable),
        .rollover_val(cnt_rollover_val), .count_out(cnt_count), .rollover_flag(cnt_rollover)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc_no, got, exp);
        end
    endtask

    // Packet-level model: what phase of the packet we are in and how many
    // payload bytes have been taken so far.
    localparam int M_IDLE = 0, M_PID = 1, M_PAY = 2, M_DONE = 3, M_DROP = 4;
    int   m_mode = M_IDLE;
    int   m_n = 0;
    bit   m_exit = 0;

    // x_* : outputs due after the coming clock edge; c_* : outputs visible now.
    bit   x_valid, x_start, x_done, x_err;
    int   x_data, x_pid, x_len, x_cnt;
    bit   c_valid, c_start, c_done, c_err;
    int   c_data, c_pid, c_len, c_cnt;
    bit   e_clear, e_enable;
    bit   have_next = 0;
    bit   reg_ok = 0;

    task automatic step();
        bit ovf;
        cyc_no++;
        c_valid = x_valid; c_start = x_start; c_done = x_done; c_err = x_err;
        c_data = x_data; c_pid = x_pid; c_len = x_len; c_cnt = x_cnt;
        reg_ok = have_next;
        have_next = 1;
        e_clear  = rst || (m_mode == M_IDLE && byte_valid && byte_data == 8'h80);
        e_enable = !rst && m_mode == M_PAY && byte_valid && m_n < 64;
        x_valid = 0; x_start = 0; x_done = 0; x_err = 0;
        if (rst) begin
            m_mode = M_IDLE; m_n = 0; m_exit = 0;
            x_data = 0; x_pid = 0; x_len = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (byte_valid && byte_data == 8'h80) begin
                    m_mode = M_PID; m_n = 0;
                end
                M_PID: begin
                    if (eop) begin
                        m_mode = M_DROP; x_err = 1; m_exit = 1;
                    end else if (byte_valid) begin
                        if ((byte_data >> 4) == ((~byte_data) & 8'h0F)) begin
                            x_pid = byte_data & 8'h0F; x_start = 1; m_mode = M_PAY;
                        end else begin
                            m_mode = M_DROP; x_err = 1; m_exit = 0;
                        end
                    end
                end
                M_PAY: begin
                    ovf = 0;
                    if (byte_valid) begin
                        if (m_n < 64) begin
                            m_n++; x_valid = 1; x_data = byte_data;
                        end else begin
                            ovf = 1;
                        end
                    end
                    if (ovf) begin
                        m_mode = M_DROP; x_err = 1; m_exit = eop;
                    end else if (eop) begin
                        m_mode = M_DONE; x_done = 1; x_len = m_n;
                    end
                end
                M_DONE: m_mode = M_IDLE;
                default: if (eop || m_exit) begin
                    m_mode = M_IDLE; m_exit = 0;
                end
            endcase
        end
        x_cnt = m_n;
    endtask

    // Observed-traffic record for the literal checks of each scenario.
    byte  got_bytes[$];
    int   n_start = 0, n_done = 0, n_err = 0;
    int   last_len = -1;

    task automatic clear_mon();
        got_bytes.delete();
        n_start = 0; n_done = 0; n_err = 0; last_len = -1;
    endtask

    // Compare DUT against the model every cycle, between clock edges.
    always @(negedge clk) begin
        if (reg_ok) begin
            chk("out_valid", 32'(out_valid), 32'(c_valid));
            chk("out_data", 32'(out_data), c_data);
            chk("pid_out", 32'(pid_out), c_pid);
            chk("pkt_start", 32'(pkt_start), 32'(c_start));
            chk("pkt_done", 32'(pkt_done), 32'(c_done));
            chk("pkt_len", 32'(pkt_len), c_len);
            chk("pkt_err", 32'(pkt_err), 32'(c_err));
            chk("cnt_count", 32'(cnt_count), c_cnt);
            chk("cnt_clear", 32'(cnt_clear), 32'(e_clear));
            chk("cnt_enable", 32'(cnt_enable), 32'(e_enable));
            chk("rollover_val", 32'(cnt_rollover_val), 64);
            if (out_valid) got_bytes.push_back(out_data);
            if (pkt_start) n_start++;
            if (pkt_done) begin n_done++; last_len = int'(pkt_len); end
            if (pkt_err) n_err++;
        end
    end

    task automatic cyc(input bit r, input bit bv, input logic [7:0] bd, input bit e);
        rst = r; byte_valid = bv; byte_data = bd; eop = e;
        step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] bd);
        cyc(0, 1, bd, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
    endtask

    initial begin
        // Reset
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);
        idle(2);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_pid", 32'(pid_out), 0);
        chk("rst_len", 32'(pkt_len), 0);
        chk("rst_count", 32'(cnt_count), 0);

        // Nominal packet
        clear_mon();
        send(8'h80); send(8'hC3); send(8'h11); send(8'h22); send(8'h33);
        cyc(0, 0, 8'h00, 1);
        idle(3);
        chk("nom_starts", n_start, 1);
        chk("nom_dones", n_done, 1);
        chk("nom_errs", n_err, 0);
        chk("nom_len", last_len, 3);
        chk("nom_pid", 32'(pid_out), 3);
        chk("nom_nbytes", got_bytes.size(), 3);
        if (got_bytes.size() == 3) begin
            chk("nom_b0", 32'(got_bytes[0]), 32'h11);
            chk("nom_b1", 32'(got_bytes[1]), 32'h22);
            chk("nom_b2", 32'(got_bytes[2]), 32'h33);
        end

        // Bad PID
        clear_mon();
        send(8'h80); send(8'hC4); send(8'h55); send(8'h66);
        cyc(0, 0, 8'h00, 1);
        idle(3);
        chk("badpid_errs", n_err, 1);
        chk("badpid_dones", n_done, 0);
        chk("badpid_nbytes", got_bytes.size(), 0);
        chk("badpid_pid_held", 32'(pid_out), 3);

        // Overflow: 65 payload bytes
        clear_mon();
        send(8'h80); send(8'hC3);
        for (int i = 0; i < 65; i++) send(8'(i + 1));
        cyc(0, 0, 8'h00, 1);
        idle(3);
        chk("ovf_nbytes", got_bytes.size(), 64);
        chk("ovf_errs", n_err, 1);
        chk("ovf_dones", n_done, 0);
        chk("ovf_count", 32'(cnt_count), 64);
        if (got_bytes.size() == 64) chk("ovf_last", 32'(got_bytes[63]), 64);

        // Zero-length payload
        clear_mon();
        send(8'h80); send(8'hC3);
        cyc(0, 0, 8'h00, 1);
        idle(3);
        chk("zero_dones", n_done, 1);
        chk("zero_len", last_len, 0);
        chk("zero_errs", n_err, 0);

        // Exactly 64 bytes, last one coincident with eop
        clear_mon();
        send(8'h80); send(8'hC3);
        for (int i = 0; i < 63; i++) send(8'(8'hA0 + i));
        cyc(0, 1, 8'h5A, 1);
        idle(3);
        chk("max_dones", n_done, 1);
        chk("max_len", last_len, 64);
        chk("max_errs", n_err, 0);
        chk("max_nbytes", got_bytes.size(), 64);
        if (got_bytes.size() == 64) chk("max_last", 32'(got_bytes[63]), 32'h5A);

        // Truncation: SYNC then eop
        clear_mon();
        send(8'h80);
        cyc(0, 0, 8'h00, 1);
        idle(3);
        chk("trunc_errs", n_err, 1);
        chk("trunc_starts", n_start, 0);

        // Noise while idle, then a good packet
        clear_mon();
        send(8'h00); send(8'hFF);
        cyc(0, 0, 8'h00, 1);
        idle(2);
        chk("noise_pulses", n_start + n_done + n_err, 0);
        chk("noise_nbytes", got_bytes.size(), 0);
        send(8'h80); send(8'h4B); send(8'h7E); send(8'h81);
        cyc(0, 0, 8'h00, 1);
        idle(3);
        chk("after_noise_pid", 32'(pid_out), 32'hB);
        chk("after_noise_len", last_len, 2);
        chk("after_noise_errs", n_err, 0);

        // Reset in the middle of the payload
        clear_mon();
        send(8'h80); send(8'hC3);
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
        cyc(1, 0, 8'h00, 0);
        idle(3);
        chk("midrst_errs", n_err, 0);
        chk("midrst_dones", n_done, 0);
        chk("midrst_count", 32'(cnt_count), 0);
        send(8'h80); send(8'h4B); send(8'hAA);
        cyc(0, 0, 8'h00, 1);
        idle(3);
        chk("midrst_pid", 32'(pid_out), 32'hB);
        chk("midrst_len", last_len, 1);
        chk("midrst_dones2", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
